// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Sequencer in front of the 3x8 row decoder of the 8x8 SRAM macro. Accepts
//   one read/write at a time, latches it, then walks a fixed non-overlapping
//   sequence: precharge -> wordline (+ write drive) -> sense (reads) -> done.
//   Every output comes straight from a flop; next-state values are computed
//   from the next FSM state so outputs line up with the state they describe.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req/we/addr/wdata  request, sampled when ready=1
//   sa_out          sense-amp outputs from the array
//   ready           idle, request accepted on req&ready edge
//   dec_a, dec_en   decoder row address / wordline fire
//   pre_en          bitline precharge enable
//   wr_en, wdrv     write-driver enable and data
//   sae             sense-amp enable
//   rvalid, rdata   read-complete pulse and captured read data
//   wdone           write-complete pulse
module sram_access_ctrl #(
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] sa_out,
    output logic       ready,
    output logic [2:0] dec_a,
    output logic       dec_en,
    output logic       pre_en,
    output logic       wr_en,
    output logic [7:0] wdrv,
    output logic       sae,
    output logic       rvalid,
    output logic       wdone,
    output logic [7:0] rdata
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_SENSE, S_DONE} state_t;

    // Counter is loaded with length-1 and the phase exits when it reads 0,
    // so a length of 1 gives exactly one cycle.
    localparam logic [3:0] PRE_LD = 4'(PRE_CYC - 1);
    localparam logic [3:0] WL_LD  = 4'(WL_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q;
    logic [2:0] addr_q;
    logic [7:0] wdata_q;

    logic       ready_q, ready_d;
    logic [2:0] dec_a_q, dec_a_d;
    logic       dec_en_q, dec_en_d;
    logic       pre_en_q, pre_en_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wdrv_q, wdrv_d;
    logic       sae_q, sae_d;
    logic       rvalid_q, rvalid_d;
    logic       wdone_q, wdone_d;
    logic [7:0] rdata_q;

    logic accept;
    assign accept = req && (state_q == S_IDLE);

    // State / output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b1;
            dec_a_q  <= '0;
            dec_en_q <= 1'b0;
            pre_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            wdrv_q   <= '0;
            sae_q    <= 1'b0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            ready_q  <= ready_d;
            dec_a_q  <= dec_a_d;
            dec_en_q <= dec_en_d;
            pre_en_q <= pre_en_d;
            wr_en_q  <= wr_en_d;
            wdrv_q   <= wdrv_d;
            sae_q    <= sae_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            // Capture on the edge leaving SENSE so rdata is valid with rvalid.
            if (state_q == S_SENSE) rdata_q <= sa_out;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_PRE;
                    cnt_d   = PRE_LD;
                end
            end
            S_PRE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACT;
                    cnt_d   = WL_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACT: begin
                if (cnt_q == 4'd0) state_d = we_q ? S_DONE : S_SENSE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_SENSE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values, decoded from the upcoming state. we_q/addr_q are
    // already settled whenever ACT or DONE is next (PRE always precedes).
    always_comb begin
        ready_d  = (state_d == S_IDLE);
        pre_en_d = (state_d == S_PRE);
        dec_en_d = (state_d == S_ACT) || (state_d == S_SENSE);
        wr_en_d  = (state_d == S_ACT) && we_q;
        wdrv_d   = wr_en_d ? wdata_q : 8'h00;
        sae_d    = (state_d == S_SENSE);
        rvalid_d = (state_d == S_DONE) && !we_q;
        wdone_d  = (state_d == S_DONE) && we_q;
        dec_a_d  = (state_d == S_ACT) ? addr_q : dec_a_q;
    end

    assign ready  = ready_q;
    assign dec_a  = dec_a_q;
    assign dec_en = dec_en_q;
    assign pre_en = pre_en_q;
    assign wr_en  = wr_en_q;
    assign wdrv   = wdrv_q;
    assign sae    = sae_q;
    assign rvalid = rvalid_q;
    assign wdone  = wdone_q;
    assign rdata  = rdata_q;

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Sequencer that sits directly upstream of the 3x8 row decoder in the 8x8 SRAM macro. It accepts one read or write request at a time and latches the address and data. It then drives the decoder address/enable, bitline precharge, write drivers and sense-amp enable in a fixed, non-overlapping timing sequence. Read data is captured from the sense-amp outputs and returned with a one-cycle valid pulse.

Parameters:
PRE_CYC, 2, precharge phase length in clk cycles (legal 1..15)
WL_CYC, 2, wordline-active phase length in clk cycles (legal 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  1  access request, sampled only when ready=1
we  input  1  1=write, 0=read; sampled with req
addr  input  3  row address; sampled with req
wdata  input  8  write data; sampled with req
sa_out  input  8  sense-amp outputs from the array
ready  output  1  controller idle; request accepted on edge where req&ready
dec_a  output  3  row address to decoder
dec_en  output  1  decoder enable (wordline fire)
pre_en  output  1  bitline precharge enable
wr_en  output  1  write-driver enable
wdrv  output  8  write-driver data
sae  output  1  sense-amp enable
rvalid  output  1  one-cycle pulse: rdata valid (reads)
wdone  output  1  one-cycle pulse: write complete
rdata  output  8  captured read data, held until next read completes

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; ready=1; dec_a=0, dec_en=0, pre_en=0, wr_en=0, wdrv=0, sae=0, rvalid=0, wdone=0, rdata=0. rst has priority over all other inputs, including req on the same edge.
- All outputs are registered: driven from flops, with no combinational path from inputs to outputs.
- Acceptance: on an edge with req=1 and ready=1, latch addr/we/wdata into internal regs. Next state is PRE, and ready=0 from the next cycle. req while ready=0 is ignored (not queued).
- States and transitions, with a 4-bit phase counter:
  - IDLE: ready=1, all enables 0. Goes to PRE on acceptance.
  - PRE: pre_en=1 for exactly PRE_CYC cycles; dec_en=0. Then ACT.
  - ACT: dec_en=1, dec_a=latched addr, pre_en=0 for exactly WL_CYC cycles.
    - Write: wr_en=1 and wdrv=latched wdata for the whole phase.
    - Read: wr_en=0, wdrv=0.
    - Exit: write goes to DONE; read goes to SENSE.
  - SENSE (read only): dec_en=1, sae=1 for one cycle. rdata<=sa_out on the edge leaving SENSE. Then DONE.
  - DONE: all enables 0 for one cycle. rvalid=1 (read) or wdone=1 (write) in this cycle. Then IDLE; ready=1 in the following cycle.
- dec_a holds its last value outside ACT/SENSE. wdrv returns to 0 when leaving ACT.
- Invariants, every cycle:
  - pre_en & dec_en = 0
  - sae -> dec_en & ~wr_en
  - wr_en -> dec_en
  - rvalid & wdone = 0
- Latency, counted in cycles after the acceptance edge:
  - Read: PRE_CYC+WL_CYC+2 cycles to the rvalid cycle (default: rvalid in cycle 6).
  - Write: PRE_CYC+WL_CYC+1 cycles to wdone (default: cycle 5).
  - Minimum request spacing is latency+1 cycles.
- Reset mid-operation: on the next edge all enables drop and the state returns to IDLE. The pending access is discarded with no rvalid/wdone, and rdata is cleared to 0.
- Boundary values: with PRE_CYC=1 and WL_CYC=1, each phase lasts one cycle. Counter reload must not produce a zero-length or extra cycle.

Test Plan:
- Reset check: assert rst for 2 cycles with req=1 -> ready=1, all enables/pulses 0, rdata=0; no access started.
- Default read: req=1, we=0, addr=5, sa_out=8'hA5 ->
  - pre_en cycles 1-2
  - dec_en with dec_a=5 cycles 3-5, sae cycle 5
  - rvalid cycle 6 with rdata=8'hA5
  - ready back cycle 7
- Default write: req=1, we=1, addr=3, wdata=8'h3C ->
  - pre_en cycles 1-2
  - dec_en/wr_en with wdrv=8'h3C cycles 3-4
  - wdone cycle 5, sae never asserted
- Busy rejection: second req with addr=7 issued during ACT of a read to addr=1 -> ignored; only addr=1 is accessed; ready stays 0 until after DONE.
- Reset mid-ACT of a write -> next cycle dec_en=wr_en=0, wdone never pulses, state IDLE, ready=1.
- Parameter sweep: PRE_CYC=1, WL_CYC=1 and PRE_CYC=15, WL_CYC=15 -> phase lengths exact. Invariants checked by assertion every cycle over 200 random read/write requests.
